// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch compare,
// and the EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module execute_cycle (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_inst,
    input  logic [31:0] i_ex_rs1_data,
    input  logic [31:0] i_ex_rs2_data,
    input  logic [31:0] i_ex_imm,
    input  logic [3:0]  i_ex_alu_op,
    input  logic        i_ex_opa_sel,
    input  logic        i_ex_opb_sel,
    input  logic        i_ex_br_un,
    input  logic        i_ex_lsu_wren,
    input  logic [2:0]  i_ex_slt_sl,
    input  logic [1:0]  i_ex_wb_sel,
    input  logic        i_ex_rd_wren,
    input  logic        i_ex_insn_vld,
    input  logic        i_ex_ctrl,
    input  logic [1:0]  i_fwd_a_sel,
    input  logic [1:0]  i_fwd_b_sel,
    input  logic [31:0] i_fwd_mem_data,
    input  logic [31:0] i_fwd_wb_data,
    input  logic        i_ex_stall,
    input  logic        i_ex_flush,
    output logic [31:0] o_ex_alu_result,
    output logic [4:0]  o_ex_rd_addr_fwd,
    output logic [31:0] o_ex_pc_mem,
    output logic [31:0] o_ex_inst_mem,
    output logic [31:0] o_ex_rs2_data_mem,
    output logic [31:0] o_ex_alu_data_mem,
    output logic        o_ex_br_equal_mem,
    output logic        o_ex_br_less_mem,
    output logic        o_ex_lsu_wren_mem,
    output logic [2:0]  o_ex_slt_sl_mem,
    output logic [1:0]  o_ex_wb_sel_mem,
    output logic        o_ex_rd_wren_mem,
    output logic        o_ex_insn_vld_mem,
    output logic        o_ex_ctrl_mem
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    logic [31:0] fa, fb, op_a, op_b, alu_res;
    logic [4:0]  shamt;
    logic        br_equal, br_less;

    always_comb begin
        fa = i_ex_rs1_data;
        case (i_fwd_a_sel)
            2'd1:    fa = i_fwd_mem_data;
            2'd2:    fa = i_fwd_wb_data;
            default: fa = i_ex_rs1_data;
        endcase
        fb = i_ex_rs2_data;
        case (i_fwd_b_sel)
            2'd1:    fb = i_fwd_mem_data;
            2'd2:    fb = i_fwd_wb_data;
            default: fb = i_ex_rs2_data;
        endcase
    end

    assign op_a  = i_ex_opa_sel ? i_ex_pc  : fa;
    assign op_b  = i_ex_opb_sel ? i_ex_imm : fb;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        case (i_ex_alu_op)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_SLL:   alu_res = op_a << shamt;
            OP_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  alu_res = {31'd0, op_a < op_b};
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SRL:   alu_res = op_a >> shamt;
            OP_SRA:   alu_res = $signed(op_a) >>> shamt;
            OP_OR:    alu_res = op_a | op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_PASSB: alu_res = op_b;
            default:  alu_res = 32'd0;
        endcase
    end

    // Branch compare sees the forwarded register values only, never PC/imm.
    assign br_equal = (fa == fb);
    assign br_less  = i_ex_br_un ? (fa < fb) : ($signed(fa) < $signed(fb));

    assign o_ex_alu_result  = alu_res;
    assign o_ex_rd_addr_fwd = i_ex_inst[11:7];

    logic [31:0] pc_q, pc_d, inst_q, inst_d, rs2_q, rs2_d, alu_q, alu_d;
    logic        br_equal_q, br_equal_d, br_less_q, br_less_d;
    logic        lsu_wren_q, lsu_wren_d;
    logic [2:0]  slt_sl_q, slt_sl_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        rd_wren_q, rd_wren_d, insn_vld_q, insn_vld_d, ctrl_q, ctrl_d;

    // Flush outranks stall: a bubble loads the datapath but kills side effects.
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        rs2_d      = rs2_q;
        alu_d      = alu_q;
        br_equal_d = br_equal_q;
        br_less_d  = br_less_q;
        lsu_wren_d = lsu_wren_q;
        slt_sl_d   = slt_sl_q;
        wb_sel_d   = wb_sel_q;
        rd_wren_d  = rd_wren_q;
        insn_vld_d = insn_vld_q;
        ctrl_d     = ctrl_q;
        if (i_ex_flush || !i_ex_stall) begin
            pc_d       = i_ex_pc;
            rs2_d      = fb;
            alu_d      = alu_res;
            br_equal_d = br_equal;
            br_less_d  = br_less;
            slt_sl_d   = i_ex_slt_sl;
            wb_sel_d   = i_ex_wb_sel;
            if (i_ex_flush) begin
                inst_d     = NOP_INST;
                lsu_wren_d = 1'b0;
                rd_wren_d  = 1'b0;
                insn_vld_d = 1'b0;
                ctrl_d     = 1'b0;
            end else begin
                inst_d     = i_ex_inst;
                lsu_wren_d = i_ex_lsu_wren;
                rd_wren_d  = i_ex_rd_wren;
                insn_vld_d = i_ex_insn_vld;
                ctrl_d     = i_ex_ctrl;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q       <= 32'd0;
            inst_q     <= 32'd0;
            rs2_q      <= 32'd0;
            alu_q      <= 32'd0;
            br_equal_q <= 1'b0;
            br_less_q  <= 1'b0;
            lsu_wren_q <= 1'b0;
            slt_sl_q   <= 3'd0;
            wb_sel_q   <= 2'd0;
            rd_wren_q  <= 1'b0;
            insn_vld_q <= 1'b0;
            ctrl_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            rs2_q      <= rs2_d;
            alu_q      <= alu_d;
            br_equal_q <= br_equal_d;
            br_less_q  <= br_less_d;
            lsu_wren_q <= lsu_wren_d;
            slt_sl_q   <= slt_sl_d;
            wb_sel_q   <= wb_sel_d;
            rd_wren_q  <= rd_wren_d;
            insn_vld_q <= insn_vld_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign o_ex_pc_mem       = pc_q;
    assign o_ex_inst_mem     = inst_q;
    assign o_ex_rs2_data_mem = rs2_q;
    assign o_ex_alu_data_mem = alu_q;
    assign o_ex_br_equal_mem = br_equal_q;
    assign o_ex_br_less_mem  = br_less_q;
    assign o_ex_lsu_wren_mem = lsu_wren_q;
    assign o_ex_slt_sl_mem   = slt_sl_q;
    assign o_ex_wb_sel_mem   = wb_sel_q;
    assign o_ex_rd_wren_mem  = rd_wren_q;
    assign o_ex_insn_vld_mem = insn_vld_q;
    assign o_ex_ctrl_mem     = ctrl_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: behavioural EX/MEM model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_execute_cycle;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset;
    logic [31:0] i_ex_pc, i_ex_inst, i_ex_rs1_data, i_ex_rs2_data, i_ex_imm;
    logic [3:0]  i_ex_alu_op;
    logic        i_ex_opa_sel, i_ex_opb_sel, i_ex_br_un, i_ex_lsu_wren;
    logic [2:0]  i_ex_slt_sl;
    logic [1:0]  i_ex_wb_sel;
    logic        i_ex_rd_wren, i_ex_insn_vld, i_ex_ctrl;
    logic [1:0]  i_fwd_a_sel, i_fwd_b_sel;
    logic [31:0] i_fwd_mem_data, i_fwd_wb_data;
    logic        i_ex_stall, i_ex_flush;
    logic [31:0] o_ex_alu_result;
    logic [4:0]  o_ex_rd_addr_fwd;
    logic [31:0] o_ex_pc_mem, o_ex_inst_mem, o_ex_rs2_data_mem, o_ex_alu_data_mem;
    logic        o_ex_br_equal_mem, o_ex_br_less_mem, o_ex_lsu_wren_mem;
    logic [2:0]  o_ex_slt_sl_mem;
    logic [1:0]  o_ex_wb_sel_mem;
    logic        o_ex_rd_wren_mem, o_ex_insn_vld_mem, o_ex_ctrl_mem;

    execute_cycle dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_ex_pc(i_ex_pc), .i_ex_inst(i_ex_inst),
        .i_ex_rs1_data(i_ex_rs1_data), .i_ex_rs2_data(i_ex_rs2_data),
        .i_ex_imm(i_ex_imm), .i_ex_alu_op(i_ex_alu_op),
        .i_ex_opa_sel(i_ex_opa_sel), .i_ex_opb_sel(i_ex_opb_sel),
        .i_ex_br_un(i_ex_br_un), .i_ex_lsu_wren(i_ex_lsu_wren),
        .i_ex_slt_sl(i_ex_slt_sl), .i_ex_wb_sel(i_ex_wb_sel),
        .i_ex_rd_wren(i_ex_rd_wren), .i_ex_insn_vld(i_ex_insn_vld),
        .i_ex_ctrl(i_ex_ctrl),
        .i_fwd_a_sel(i_fwd_a_sel), .i_fwd_b_sel(i_fwd_b_sel),
        .i_fwd_mem_data(i_fwd_mem_data), .i_fwd_wb_data(i_fwd_wb_data),
        .i_ex_stall(i_ex_stall), .i_ex_flush(i_ex_flush),
        .o_ex_alu_result(o_ex_alu_result), .o_ex_rd_addr_fwd(o_ex_rd_addr_fwd),
        .o_ex_pc_mem(o_ex_pc_mem), .o_ex_inst_mem(o_ex_inst_mem),
        .o_ex_rs2_data_mem(o_ex_rs2_data_mem), .o_ex_alu_data_mem(o_ex_alu_data_mem),
        .o_ex_br_equal_mem(o_ex_br_equal_mem), .o_ex_br_less_mem(o_ex_br_less_mem),
        .o_ex_lsu_wren_mem(o_ex_lsu_wren_mem), .o_ex_slt_sl_mem(o_ex_slt_sl_mem),
        .o_ex_wb_sel_mem(o_ex_wb_sel_mem), .o_ex_rd_wren_mem(o_ex_rd_wren_mem),
        .o_ex_insn_vld_mem(o_ex_insn_vld_mem), .o_ex_ctrl_mem(o_ex_ctrl_mem)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc, inst, rs2, alu;
        logic        beq, blt, lsu;
        logic [2:0]  slt;
        logic [1:0]  wb;
        logic        rdw, vld, ctrl;
    } mem_t;

    mem_t m_q;
    bit   m_ok = 1'b0;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return i_fwd_mem_data;
        if (sel == 2'd2) return i_fwd_wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] model_alu();
        logic [31:0] a, b;
        logic [63:0] wide;
        int          sh;
        longint      sa, sb;
        a    = i_ex_opa_sel ? i_ex_pc : pick(i_fwd_a_sel, i_ex_rs1_data);
        b    = i_ex_opb_sel ? i_ex_imm : pick(i_fwd_b_sel, i_ex_rs2_data);
        sh   = b % 32;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        case (i_ex_alu_op)
            4'd0:  wide = 64'(a) + 64'(b);
            4'd1:  wide = 64'(a) + 64'(~b) + 64'd1;
            4'd2:  wide = 64'(a) * (64'd1 << sh);
            4'd3:  wide = (sa < sb) ? 64'd1 : 64'd0;
            4'd4:  wide = (64'(a) < 64'(b)) ? 64'd1 : 64'd0;
            4'd5:  wide = 64'(a ^ b);
            4'd6:  wide = 64'(a) / (64'd1 << sh);
            4'd7:  wide = {{32{a[31]}}, a} >> sh;
            4'd8:  wide = 64'(a | b);
            4'd9:  wide = 64'(a & b);
            4'd10: wide = 64'(b);
            default: wide = 64'd0;
        endcase
        return wide[31:0];
    endfunction

    function automatic mem_t model_next(input bit bubble);
        mem_t n;
        logic [31:0] fa, fb;
        fa     = pick(i_fwd_a_sel, i_ex_rs1_data);
        fb     = pick(i_fwd_b_sel, i_ex_rs2_data);
        n.pc   = i_ex_pc;
        n.inst = bubble ? 32'h13 : i_ex_inst;
        n.rs2  = fb;
        n.alu  = model_alu();
        n.beq  = (fa == fb);
        n.blt  = i_ex_br_un ? (64'(fa) < 64'(fb))
                            : (longint'($signed(fa)) < longint'($signed(fb)));
        n.lsu  = bubble ? 1'b0 : i_ex_lsu_wren;
        n.slt  = i_ex_slt_sl;
        n.wb   = i_ex_wb_sel;
        n.rdw  = bubble ? 1'b0 : i_ex_rd_wren;
        n.vld  = bubble ? 1'b0 : i_ex_insn_vld;
        n.ctrl = bubble ? 1'b0 : i_ex_ctrl;
        return n;
    endfunction

    always @(posedge clk) begin
        if (i_reset) begin
            m_q  <= '0;
            m_ok <= 1'b1;
        end else if (i_ex_flush) m_q <= model_next(1'b1);
        else if (!i_ex_stall)    m_q <= model_next(1'b0);
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_pc",   o_ex_pc_mem,       m_q.pc);
            chk("m_inst", o_ex_inst_mem,     m_q.inst);
            chk("m_rs2",  o_ex_rs2_data_mem, m_q.rs2);
            chk("m_alu",  o_ex_alu_data_mem, m_q.alu);
            chk("m_beq",  32'(o_ex_br_equal_mem), 32'(m_q.beq));
            chk("m_blt",  32'(o_ex_br_less_mem),  32'(m_q.blt));
            chk("m_lsu",  32'(o_ex_lsu_wren_mem), 32'(m_q.lsu));
            chk("m_slt",  32'(o_ex_slt_sl_mem),   32'(m_q.slt));
            chk("m_wb",   32'(o_ex_wb_sel_mem),   32'(m_q.wb));
            chk("m_rdw",  32'(o_ex_rd_wren_mem),  32'(m_q.rdw));
            chk("m_vld",  32'(o_ex_insn_vld_mem), 32'(m_q.vld));
            chk("m_ctrl", 32'(o_ex_ctrl_mem),     32'(m_q.ctrl));
            chk("m_alu_comb", o_ex_alu_result, model_alu());
            chk("m_rd_fwd",   32'(o_ex_rd_addr_fwd), 32'((i_ex_inst >> 7) & 32'h1F));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear();
        i_ex_pc = 32'h0; i_ex_inst = 32'h0; i_ex_rs1_data = 32'h0; i_ex_rs2_data = 32'h0;
        i_ex_imm = 32'h0; i_ex_alu_op = 4'd0; i_ex_opa_sel = 1'b0; i_ex_opb_sel = 1'b0;
        i_ex_br_un = 1'b0; i_ex_lsu_wren = 1'b0; i_ex_slt_sl = 3'd0; i_ex_wb_sel = 2'd0;
        i_ex_rd_wren = 1'b0; i_ex_insn_vld = 1'b0; i_ex_ctrl = 1'b0;
        i_fwd_a_sel = 2'd0; i_fwd_b_sel = 2'd0; i_fwd_mem_data = 32'h0; i_fwd_wb_data = 32'h0;
        i_ex_stall = 1'b0; i_ex_flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_add();
        clear();
        i_ex_pc = 32'h100; i_ex_inst = 32'h00A0_0093;
        i_ex_rs1_data = 32'd5; i_ex_rs2_data = 32'd7;
        i_ex_rd_wren = 1'b1; i_ex_insn_vld = 1'b1; i_ex_ctrl = 1'b1;
        i_ex_wb_sel = 2'd1; i_ex_slt_sl = 3'd2;
    endtask

    initial begin
        clear();
        i_reset = 1'b1;
        step();
        step();
        $display("reset: alu=%h vld=%b inst=%h", o_ex_alu_data_mem, o_ex_insn_vld_mem, o_ex_inst_mem);
        chk("reset_alu", o_ex_alu_data_mem, 32'h0);
        chk("reset_vld", 32'(o_ex_insn_vld_mem), 32'h0);
        i_reset = 1'b0;

        load_add();
        step();
        $display("add: alu=%h comb=%h rd_fwd=%0d", o_ex_alu_data_mem, o_ex_alu_result, o_ex_rd_addr_fwd);
        chk("add_alu", o_ex_alu_data_mem, 32'd12);
        chk("add_rdw", 32'(o_ex_rd_wren_mem), 32'd1);
        chk("add_comb", o_ex_alu_result, 32'd12);
        chk("add_rdfwd", 32'(o_ex_rd_addr_fwd), 32'd1);

        clear(); i_ex_rs1_data = 32'h8000_0000; i_ex_imm = 32'd4; i_ex_opb_sel = 1'b1; i_ex_alu_op = 4'd7;
        step();
        $display("sra: alu=%h", o_ex_alu_data_mem);
        chk("sra", o_ex_alu_data_mem, 32'hF800_0000);

        clear(); i_ex_rs1_data = 32'hFFFF_FFFF; i_ex_rs2_data = 32'd1; i_ex_alu_op = 4'd3;
        step();
        $display("slt: alu=%h", o_ex_alu_data_mem);
        chk("slt", o_ex_alu_data_mem, 32'd1);
        i_ex_alu_op = 4'd4;
        step();
        $display("sltu: alu=%h", o_ex_alu_data_mem);
        chk("sltu", o_ex_alu_data_mem, 32'd0);

        clear(); i_fwd_a_sel = 2'd1; i_fwd_mem_data = 32'd100; i_ex_rs2_data = 32'd1;
        step();
        $display("fwd_a: alu=%h", o_ex_alu_data_mem);
        chk("fwd_a", o_ex_alu_data_mem, 32'd101);

        clear(); i_fwd_b_sel = 2'd2; i_fwd_wb_data = 32'hAA; i_ex_rs2_data = 32'h5;
        i_ex_imm = 32'h8; i_ex_opb_sel = 1'b1; i_ex_lsu_wren = 1'b1;
        step();
        $display("store: rs2=%h lsu=%b", o_ex_rs2_data_mem, o_ex_lsu_wren_mem);
        chk("store_data", o_ex_rs2_data_mem, 32'hAA);
        i_fwd_b_sel = 2'd3;
        step();
        $display("fwd_b3: rs2=%h", o_ex_rs2_data_mem);
        chk("fwd_b3", o_ex_rs2_data_mem, 32'h5);

        clear(); i_ex_rs1_data = 32'hFFFF_FFFE; i_ex_rs2_data = 32'd1;
        i_ex_opb_sel = 1'b1; i_ex_imm = 32'hFFFF_FFFE;
        step();
        $display("br signed: less=%b eq=%b", o_ex_br_less_mem, o_ex_br_equal_mem);
        chk("blt_s", 32'(o_ex_br_less_mem), 32'd1);
        chk("beq_s", 32'(o_ex_br_equal_mem), 32'd0);
        i_ex_br_un = 1'b1;
        step();
        $display("br unsigned: less=%b eq=%b", o_ex_br_less_mem, o_ex_br_equal_mem);
        chk("blt_u", 32'(o_ex_br_less_mem), 32'd0);
        chk("beq_u", 32'(o_ex_br_equal_mem), 32'd0);

        for (int op = 0; op < 16; op++) begin
            clear(); i_ex_rs1_data = 32'h8000_00F3; i_ex_rs2_data = 32'h0000_0024;
            i_ex_alu_op = 4'(op); i_ex_pc = 32'h40 + 32'(op);
            step();
            $display("op %0d: alu=%h", op, o_ex_alu_data_mem);
        end
        chk("op15_zero", o_ex_alu_data_mem, 32'd0);

        load_add();
        step();
        for (int i = 0; i < 3; i++) begin
            i_ex_stall = 1'b1; i_ex_rs1_data = 32'd50 + 32'(i); i_ex_pc = 32'h900 + 32'(i);
            i_ex_insn_vld = 1'b0; i_ex_inst = 32'hDEAD_BEEF;
            step();
            $display("stall %0d: alu=%h pc=%h vld=%b", i, o_ex_alu_data_mem, o_ex_pc_mem, o_ex_insn_vld_mem);
            chk("stall_alu", o_ex_alu_data_mem, 32'd12);
            chk("stall_pc", o_ex_pc_mem, 32'h100);
        end
        i_ex_flush = 1'b1; i_ex_stall = 1'b1; i_ex_insn_vld = 1'b1; i_ex_rd_wren = 1'b1;
        i_ex_rs1_data = 32'd3;
        step();
        $display("flush: vld=%b inst=%h alu=%h", o_ex_insn_vld_mem, o_ex_inst_mem, o_ex_alu_data_mem);
        chk("flush_vld", 32'(o_ex_insn_vld_mem), 32'd0);
        chk("flush_inst", o_ex_inst_mem, 32'h0000_0013);
        chk("flush_rdw", 32'(o_ex_rd_wren_mem), 32'd0);
        chk("flush_alu", o_ex_alu_data_mem, 32'd10);

        load_add();
        step();
        i_reset = 1'b1;
        step();
        $display("mid reset: alu=%h pc=%h vld=%b", o_ex_alu_data_mem, o_ex_pc_mem, o_ex_insn_vld_mem);
        chk("mrst_alu", o_ex_alu_data_mem, 32'd0);
        chk("mrst_pc", o_ex_pc_mem, 32'd0);
        chk("mrst_vld", 32'(o_ex_insn_vld_mem), 32'd0);
        i_reset = 1'b0;
        step();
        $display("resume: alu=%h vld=%b", o_ex_alu_data_mem, o_ex_insn_vld_mem);
        chk("resume_alu", o_ex_alu_data_mem, 32'd12);
        chk("resume_vld", 32'(o_ex_insn_vld_mem), 32'd1);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the 5-stage RV32I pipeline: sits between decode and `memory_cycle`. It resolves rs1/rs2 forwarding, computes the ALU result and branch compare flags, and registers everything `memory_cycle` consumes into the EX/MEM pipeline register. It also supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
- No parameters.
- `i_clk` in 1: clock; all state on rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_ex_pc`, `i_ex_inst`, `i_ex_rs1_data`, `i_ex_rs2_data`, `i_ex_imm` in 32 each: PC, instruction, register-file operands, and immediate from decode.
- `i_ex_alu_op` in 4: ALU operation (encoding below).
- `i_ex_opa_sel` in 1: 0 = rs1, 1 = PC.
- `i_ex_opb_sel` in 1: 0 = rs2, 1 = imm.
- `i_ex_br_un` in 1: 1 = unsigned branch compare.
- `i_ex_lsu_wren` in 1, `i_ex_slt_sl` in 3: MEM control, passed through.
- `i_ex_wb_sel` in 2, `i_ex_rd_wren` in 1, `i_ex_insn_vld` in 1, `i_ex_ctrl` in 1: WB control, passed through.
- `i_fwd_a_sel`, `i_fwd_b_sel` in 2 each: forward select for rs1/rs2. 0 = regfile, 1 = `i_fwd_mem_data`, 2 = `i_fwd_wb_data`, 3 = regfile.
- `i_fwd_mem_data`, `i_fwd_wb_data` in 32 each: ALU data in MEM; final WB data.
- `i_ex_stall` in 1: hold EX/MEM register.
- `i_ex_flush` in 1: load a bubble into EX/MEM.
- `o_ex_alu_result` out 32: combinational ALU result, used as branch/jump target.
- `o_ex_rd_addr_fwd` out 5: combinational `i_ex_inst[11:7]`.
- Registered outputs to `memory_cycle`:
  - `o_ex_pc_mem` 32, `o_ex_inst_mem` 32
  - `o_ex_rs2_data_mem` 32: forwarded rs2
  - `o_ex_alu_data_mem` 32
  - `o_ex_br_equal_mem` 1, `o_ex_br_less_mem` 1
  - `o_ex_lsu_wren_mem` 1, `o_ex_slt_sl_mem` 3, `o_ex_wb_sel_mem` 2
  - `o_ex_rd_wren_mem` 1, `o_ex_insn_vld_mem` 1, `o_ex_ctrl_mem` 1

## Operation
- Forwarding: `fa` and `fb` are the rs1/rs2 values after the forward muxes.
- Operand A = `opa_sel ? pc : fa`. Operand B = `opb_sel ? imm : fb`.
- Branch compare always uses `fa`/`fb`, never the immediate or PC.
  - `br_equal` = (fa == fb).
  - `br_less` = unsigned fa < fb when `br_un`=1, signed otherwise.
- Store data is `fb`.
- ALU ops, 32-bit, wrap-around, no flags. Shift amount is B[4:0].
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed, result 0/1), 4 SLTU, 5 XOR, 6 SRL, 7 SRA
  - 8 OR, 9 AND, 10 PASSB (LUI)
  - 11–15: result 0
- EX/MEM register priority: reset > flush > stall > load.
  - Reset: all registered outputs 0.
  - Flush: `rd_wren`, `lsu_wren`, `insn_vld`, `ctrl` forced to 0 and `inst` set to 0x00000013. Other fields load normally.
  - Stall (without flush): every register holds its value.
  - Otherwise: load the computed values and the pass-through controls.
- Flush and stall in the same cycle: flush wins.
- Combinational outputs follow the inputs regardless of stall or flush.

## Timing
- Latency: 1 cycle from EX inputs to `_mem` outputs.
- `o_ex_alu_result` and `o_ex_rd_addr_fwd` have 0-cycle latency.
- Reset takes effect at the first rising edge with `i_reset`=1, including mid-operation; outputs read 0 on the following cycle.
- Stall is checked on every edge; any number of consecutive stall cycles holds indefinitely.
- Single critical path: fwd mux → ALU → register. No multicycle ops.

## Test plan
- ADD: rs1=5, rs2=7, op=0, sels=0 → next cycle `alu_data_mem`=12, `rd_wren_mem` follows input.
- SRA and SLT:
  - SRA: rs1=0x80000000, imm=4, opb_sel=1, op=7 → 0xF8000000.
  - SLT: rs1=0xFFFFFFFF, rs2=1, op=3 → 1; op=4 → 0.
- Forwarding:
  - fwd_a_sel=1, `i_fwd_mem_data`=100, rs1=0, rs2=1, op=0 → 101.
  - fwd_b_sel=2, `i_fwd_wb_data`=0xAA, store → `rs2_data_mem`=0xAA.
- Branch flags: fa=0xFFFFFFFE, fb=1.
  - br_un=0 → `br_less_mem`=1.
  - br_un=1 → `br_less_mem`=0.
  - `br_equal_mem`=0 in both cases.
- Stall and flush:
  - Load a valid op, then stall 3 cycles with changing inputs → outputs unchanged.
  - Stall+flush together → `insn_vld_mem`=0, `inst_mem`=0x00000013.
- Reset mid-stream: pipeline busy, assert `i_reset` for 1 cycle → all `_mem` outputs 0 the next cycle; normal load resumes after release.
